param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_ram_2p.sv | 26 ++
 rtl/param_sync_fifo.sv | 128 ++++++++++++
 tb/tb_param_sync_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Pointer width carries one extra wrap bit above the index.
package fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AF_LEVEL = 12;
  localparam int DEF_AE_LEVEL = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Storage array: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module fifo_ram_2p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with status and sticky errors.
// Status is combinational from the registered pointers.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  input  logic                      clr_err,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("param_sync_fifo: AE_LEVEL must be below AF_LEVEL");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_LEVEL must not exceed DEPTH");
  end

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              wr_acc;
  logic              rd_acc;

  assign count        = wptr_q - rptr_q;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  fifo_ram_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (wr_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_acc) begin
      rptr_d     = rptr_q + 1'b1;
      rd_data_d  = ram_rdata;
      rd_valid_d = 1'b1;
    end
    // A fresh error in the same cycle beats the clear.
    if (wr_en && !wr_acc) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end
    if (rd_en && !rd_acc) begin
      udf_d = 1'b1;
    end else if (clr_err) begin
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed plus random bench for param_sync_fifo.
// Expected values come from a queue-based reference model.
module tb_param_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clr_err;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  param_sync_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DP),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .clr_err      (clr_err),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  logic          m_rv;
  logic          m_ovf;
  logic          m_udf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count"}, 32'(count), 32'(n));
    chk({tag, ":full"}, 32'(full), 32'(n == DP));
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":af"}, 32'(almost_full), 32'(n >= AF));
    chk({tag, ":ae"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ":rv"}, 32'(rd_valid), 32'(m_rv));
    chk({tag, ":rd"}, 32'(rd_data), 32'(m_rd));
    chk({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ":udf"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic model_reset();
    q.delete();
    m_rd  = '0;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic we, input logic [DW-1:0] wd,
                      input logic re, input logic ce,
                      input string tag);
    bit wacc, racc;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    clr_err = ce;
    wacc = we && (q.size() < DP);
    racc = re && (q.size() > 0);
    m_rv = 1'b0;
    if (racc) begin
      m_rd = q.pop_front();
      m_rv = 1'b1;
    end
    if (wacc) q.push_back(wd);
    if (we && !wacc) m_ovf = 1'b1;
    else if (ce) m_ovf = 1'b0;
    if (re && !racc) m_udf = 1'b1;
    else if (ce) m_udf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    model_reset();
    #2;
    chk_all("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk_all("post_rst");

    for (int i = 1; i <= 16; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, "fill");
    end
    chk("fill_full", 32'(full), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, "drain");
      chk("drain_seq", 32'(rd_data), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 16; i++) begin
      step(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, "refill");
    end
    step(1'b1, 8'hEE, 1'b0, 1'b0, "ovf");
    chk("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, "ovf_clr");
    chk("ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, "ovf_drain");
      chk("no_store", 32'(rd_data), 32'(8'hA0 + i));
    end

    step(1'b0, '0, 1'b1, 1'b0, "udf");
    chk("udf_set", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, "udf_clr");
    step(1'b1, 8'h5A, 1'b1, 1'b0, "empty_rw");
    chk("empty_rw_cnt", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1, 1'b1, "clr_drain");

    while (q.size() < DP) begin
      step(1'b1, DW'($urandom), 1'b0, 1'b0, "fill2");
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'($urandom), 1'b1, 1'b0, "rw40");
    end
    step(1'b1, 8'h11, 1'b1, 1'b1, "set_over_clr");
    while (q.size() > 0) begin
      step(1'b0, '0, 1'b1, 1'b0, "drain2");
    end

    for (int i = 0; i < DP; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, "stair");
    end
    while (q.size() > 0) begin
      step(1'b0, '0, 1'b1, 1'b0, "stair_dn");
    end

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), DW'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0), "rand");
    end

    while (q.size() > 9) step(1'b0, '0, 1'b1, 1'b0, "to9");
    while (q.size() < 9) step(1'b1, DW'($urandom), 1'b0, 1'b0, "to9");
    step(1'b1, 8'h77, 1'b0, 1'b0, "pre_rst");
    step(1'b0, '0, 1'b1, 1'b0, "pre_rst");
    chk("cnt9", 32'(count), 32'd9);
    #2;
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_reset();
    #1;
    chk_all("async_rst");
    @(negedge clk);
    chk_all("rst_held");
    reset = 1'b1;
    step(1'b1, 8'h3C, 1'b1, 1'b0, "after_rst");
    step(1'b0, '0, 1'b1, 1'b0, "after_rst_rd");
    chk("after_rst_data", 32'(rd_data), 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
